// File: rtl/ir_pkg.sv
// ----------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the NEC infrared transmitter.
//   - ir_state_t : transmitter state machine encoding
//   - *_TICKS    : NEC segment lengths in units of 562.5 us
//   - NEC_FRAME_W: width of the serialised NEC frame
//   - nec_frame(): builds the 32-bit frame from address and command
// ----------------------------------------------------------------------------
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    REP_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } ir_state_t;

  localparam int LEAD_MARK_TICKS  = 16;
  localparam int LEAD_SPACE_TICKS = 8;
  localparam int REP_SPACE_TICKS  = 4;
  localparam int BIT_MARK_TICKS   = 1;
  localparam int ZERO_SPACE_TICKS = 1;
  localparam int ONE_SPACE_TICKS  = 3;
  localparam int STOP_TICKS       = 1;

  localparam int NEC_FRAME_W = 32;

  // Address goes out first, LSB first, followed by its complement, then the
  // command and its complement; bit 0 of the result is the first bit on air.
  function automatic logic [NEC_FRAME_W-1:0] nec_frame(input logic [7:0] addr,
                                                       input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ----------------------------------------------------------------------------
// ir_carrier_gen
// Free-running carrier generator with a registered output.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   en       : envelope value for the coming cycle (1 = mark)
//   restart  : coming cycle is the first of a mark; phase restarts at 0
//   carrier  : registered carrier, high for CARRIER_HIGH of every
//              CARRIER_DIV clocks while enabled, low otherwise
// The inputs describe the next cycle, so the registered output lines up
// with the registered envelope of the instantiating module.
// ----------------------------------------------------------------------------
module ir_carrier_gen
  import ir_pkg::*;
#(
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic carrier
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(CARRIER_HIGH);

  logic [CW-1:0] carr_cnt;
  logic [CW-1:0] cnt_nxt;

  // Count is held at zero through spaces and forced to zero at mark start,
  // so every mark opens with the carrier in its high phase.
  always_comb begin
    cnt_nxt = '0;
    if (en && !restart && (carr_cnt != CNT_LAST)) begin
      cnt_nxt = carr_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carr_cnt <= '0;
      carrier  <= 1'b0;
    end else begin
      carr_cnt <= cnt_nxt;
      carrier  <= en && (cnt_nxt < CNT_HIGH);
    end
  end

endmodule

// File: rtl/ir_transmit.sv
// ----------------------------------------------------------------------------
// ir_transmit
// NEC-protocol infrared transmitter. Accepts an address/command pair (or a
// repeat-code request) over valid/ready, serialises it as a mark/space
// envelope and drives the LED with that envelope gated by a ~38 kHz carrier.
//
// Ports
//   clk_clk        : system clock
//   reset_reset_n  : asynchronous active-low reset
//   tx_valid       : request to send
//   tx_ready       : request can be accepted (only while idle)
//   tx_repeat      : 1 = send repeat code, tx_addr/tx_cmd ignored
//   tx_addr        : NEC address
//   tx_cmd         : NEC command
//   tx_busy        : transmitter not idle
//   tx_done        : one-cycle pulse on the last clock of the stop mark
//   ir_env         : unmodulated envelope (1 = mark)
//   ir_out         : modulated LED drive, optionally inverted
//   led            : activity indicator (mirrors tx_busy)
//
// All outputs come from registers. Each segment of N ticks occupies exactly
// N*TICK_CYCLES clocks; the following state starts on the next clock.
// ----------------------------------------------------------------------------
module ir_transmit
  import ir_pkg::*;
#(
  parameter int TICK_CYCLES    = 28125,
  parameter int CARRIER_DIV    = 1316,
  parameter int CARRIER_HIGH   = 439,
  parameter int GAP_TICKS      = 72,
  parameter int OUT_ACTIVE_LOW = 0
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_repeat,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ir_env,
  output logic       ir_out,
  output logic       led
);

  localparam int TICK_W  = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int SEG_MAX = (GAP_TICKS > LEAD_MARK_TICKS) ? GAP_TICKS : LEAD_MARK_TICKS;
  localparam int SEG_W   = $clog2(SEG_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(TICK_CYCLES - 2);
  localparam logic [SEG_W-1:0]  SEG_ONE   = SEG_W'(1);
  localparam logic              OUT_INV   = (OUT_ACTIVE_LOW != 0);

  ir_state_t               state;
  logic [TICK_W-1:0]       tick_cnt;
  logic [SEG_W-1:0]        seg_cnt;
  logic [4:0]              bit_idx;
  logic                    rep_q;
  logic [NEC_FRAME_W-1:0]  frame_sr;

  logic accept;
  logic seg_last;
  logic env_nxt;
  logic mark_start;
  logic carrier;

  function automatic logic [SEG_W-1:0] seg_len(input int ticks);
    return SEG_W'(ticks);
  endfunction

  assign accept     = tx_valid && tx_ready;
  assign seg_last   = (state != IDLE) && (tick_cnt == TICK_LAST) && (seg_cnt == SEG_ONE);
  assign mark_start = env_nxt && !ir_env;

  // Envelope for the coming cycle. Level only changes on acceptance or at a
  // segment boundary; the level after a boundary depends only on the state
  // being left, since marks and spaces always alternate.
  always_comb begin
    env_nxt = ir_env;
    if (accept) begin
      env_nxt = 1'b1;
    end else if (seg_last) begin
      case (state)
        LEAD_SPACE, REP_SPACE, BIT_SPACE: env_nxt = 1'b1;
        default:                          env_nxt = 1'b0;
      endcase
    end
  end

  // ---- stage: control FSM and timing counters ----
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      seg_cnt  <= '0;
      bit_idx  <= '0;
      rep_q    <= 1'b0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      ir_env   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      ir_env  <= env_nxt;
      if (state == IDLE) begin
        tick_cnt <= '0;
        if (accept) begin
          state    <= LEAD_MARK;
          seg_cnt  <= seg_len(LEAD_MARK_TICKS);
          rep_q    <= tx_repeat;
          bit_idx  <= '0;
          tx_ready <= 1'b0;
          tx_busy  <= 1'b1;
        end
      end else begin
        // Registered pulse must be high during the final clock of the stop
        // mark, so it is armed one clock early.
        if ((state == STOP_MARK) && (seg_cnt == SEG_ONE) && (tick_cnt == TICK_PRE)) begin
          tx_done <= 1'b1;
        end
        if (tick_cnt != TICK_LAST) begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end else begin
          tick_cnt <= '0;
          if (seg_cnt != SEG_ONE) begin
            seg_cnt <= seg_cnt - SEG_ONE;
          end else begin
            case (state)
              LEAD_MARK: begin
                if (rep_q) begin
                  state   <= REP_SPACE;
                  seg_cnt <= seg_len(REP_SPACE_TICKS);
                end else begin
                  state   <= LEAD_SPACE;
                  seg_cnt <= seg_len(LEAD_SPACE_TICKS);
                end
              end
              LEAD_SPACE: begin
                state   <= BIT_MARK;
                seg_cnt <= seg_len(BIT_MARK_TICKS);
                bit_idx <= '0;
              end
              REP_SPACE: begin
                state   <= STOP_MARK;
                seg_cnt <= seg_len(STOP_TICKS);
              end
              BIT_MARK: begin
                state   <= BIT_SPACE;
                seg_cnt <= frame_sr[0] ? seg_len(ONE_SPACE_TICKS)
                                       : seg_len(ZERO_SPACE_TICKS);
              end
              BIT_SPACE: begin
                if (bit_idx == 5'd31) begin
                  state   <= STOP_MARK;
                  seg_cnt <= seg_len(STOP_TICKS);
                end else begin
                  state   <= BIT_MARK;
                  seg_cnt <= seg_len(BIT_MARK_TICKS);
                  bit_idx <= bit_idx + 5'd1;
                end
              end
              STOP_MARK: begin
                state   <= GAP;
                seg_cnt <= seg_len(GAP_TICKS);
              end
              default: begin
                state    <= IDLE;
                seg_cnt  <= '0;
                tx_ready <= 1'b1;
                tx_busy  <= 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

  // ---- stage: frame shift register ----
  always_ff @(posedge clk_clk) begin
    if (accept) begin
      frame_sr <= nec_frame(tx_addr, tx_cmd);
    end else if ((state == BIT_SPACE) && seg_last) begin
      frame_sr <= frame_sr >> 1;
    end
  end

  // ---- stage: carrier modulation ----
  ir_carrier_gen #(
    .CARRIER_DIV  (CARRIER_DIV),
    .CARRIER_HIGH (CARRIER_HIGH)
  ) u_carrier (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .en      (env_nxt),
    .restart (mark_start),
    .carrier (carrier)
  );

  assign ir_out = carrier ^ OUT_INV;
  assign led    = tx_busy;

endmodule

// File: tb/tb_ir_transmit.sv
module tb_ir_transmit;

  localparam int TICK = 4;
  localparam int DIV  = 3;
  localparam int HIGH = 1;
  localparam int GAPT = 8;
  localparam int NMAX = 1200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_repeat;
  logic [7:0] tx_addr;
  logic [7:0] tx_cmd;
  logic       tx_busy;
  logic       tx_done;
  logic       ir_env;
  logic       ir_out;
  logic       led;

  int total = 0;
  int bad   = 0;

  logic env_a  [1:NMAX];
  logic out_a  [1:NMAX];
  logic done_a [1:NMAX];
  logic rdy_a  [1:NMAX];
  logic led_a  [1:NMAX];
  int   run_len [0:199];
  logic run_lvl [0:199];
  int   n_runs;

  always #5 clk = ~clk;

  ir_transmit #(
    .TICK_CYCLES    (TICK),
    .CARRIER_DIV    (DIV),
    .CARRIER_HIGH   (HIGH),
    .GAP_TICKS      (GAPT),
    .OUT_ACTIVE_LOW (0)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_repeat     (tx_repeat),
    .tx_addr       (tx_addr),
    .tx_cmd        (tx_cmd),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .ir_env        (ir_env),
    .ir_out        (ir_out),
    .led           (led)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples cycles T+1..T+n (called right after the accepting edge).
  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      env_a[k]  = ir_env;
      out_a[k]  = ir_out;
      done_a[k] = tx_done;
      rdy_a[k]  = tx_ready;
      led_a[k]  = led;
      step();
    end
  endtask

  task automatic decode(input int n);
    n_runs     = 0;
    run_lvl[0] = env_a[1];
    run_len[0] = 0;
    for (int k = 1; k <= n; k++) begin
      if (env_a[k] === run_lvl[n_runs]) begin
        run_len[n_runs]++;
      end else if (n_runs < 199) begin
        n_runs++;
        run_lvl[n_runs] = env_a[k];
        run_len[n_runs] = 1;
      end
    end
    n_runs++;
  endtask

  task automatic send(input logic rep, input logic [7:0] a, input logic [7:0] c,
                      input logic hold);
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 2000) begin
      step();
      w++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready got=%b want=1", tx_ready);
    end
    tx_valid  = 1'b1;
    tx_repeat = rep;
    tx_addr   = a;
    tx_cmd    = c;
    step();
    if (!hold) tx_valid = 1'b0;
    tx_repeat = 1'b0;
    tx_addr   = 8'h5A;
    tx_cmd    = 8'hC3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_valid = 1'b0; tx_repeat = 1'b0; tx_addr = 8'h00; tx_cmd = 8'h00;
    step(); step(); step();
    rst_n = 1'b1;
    step(); step();
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", tx_ready); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", tx_busy); end
    total++; if (ir_env !== 1'b0) begin bad++; $display("FAIL rst_env got=%b want=0", ir_env); end
    total++; if (ir_out !== 1'b0) begin bad++; $display("FAIL rst_out got=%b want=0", ir_out); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", tx_done); end
    total++; if (led !== 1'b0) begin bad++; $display("FAIL rst_led got=%b want=0", led); end
  endtask

  task automatic test_full_frame();
    int errs, hi, dfirst, dcnt;
    send(1'b0, 8'h00, 8'hFF, 1'b0);
    capture(530);
    decode(530);
    total++; if (rdy_a[1] !== 1'b0) begin bad++; $display("FAIL ff_ready_drop got=%b want=0", rdy_a[1]); end
    total++; if (led_a[1] !== 1'b1) begin bad++; $display("FAIL ff_led got=%b want=1", led_a[1]); end
    total++; if (run_lvl[0] !== 1'b1 || run_len[0] != 64) begin
      bad++; $display("FAIL ff_lead_mark got=%b/%0d want=1/64", run_lvl[0], run_len[0]); end
    total++; if (run_len[1] != 32) begin bad++; $display("FAIL ff_lead_space got=%0d want=32", run_len[1]); end
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (run_len[2+2*i] != 4 || run_len[3+2*i] != 4) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL ff_first8 bad_bits got=%0d want=0", errs); end
    hi = 0; dfirst = 0; dcnt = 0;
    for (int k = 1; k <= 530; k++) begin
      if (env_a[k] === 1'b1) hi++;
      if (done_a[k] === 1'b1) begin dcnt++; if (dfirst == 0) dfirst = k; end
    end
    total++; if (dfirst != 484) begin bad++; $display("FAIL ff_done_at got=%0d want=484", dfirst); end
    total++; if (dcnt != 1) begin bad++; $display("FAIL ff_done_cnt got=%0d want=1", dcnt); end
    total++; if (hi != 196) begin bad++; $display("FAIL ff_high_cycles got=%0d want=196", hi); end
    total++; if (rdy_a[516] !== 1'b0) begin bad++; $display("FAIL ff_gap_ready got=%b want=0", rdy_a[516]); end
    total++; if (rdy_a[517] !== 1'b1) begin bad++; $display("FAIL ff_idle_ready got=%b want=1", rdy_a[517]); end
    total++; if (led_a[517] !== 1'b0) begin bad++; $display("FAIL ff_idle_led got=%b want=0", led_a[517]); end
  endtask

  task automatic test_bit_decode();
    logic [31:0] word;
    int odd;
    send(1'b0, 8'h04, 8'h08, 1'b0);
    capture(530);
    decode(530);
    word = '0;
    odd  = 0;
    for (int i = 0; i < 32; i++) begin
      word[i] = (run_len[3+2*i] == 12);
      if (run_len[3+2*i] != 4 && run_len[3+2*i] != 12) odd++;
    end
    total++; if (run_len[3] != 4) begin bad++; $display("FAIL bd_space0 got=%0d want=4", run_len[3]); end
    total++; if (run_len[5] != 4) begin bad++; $display("FAIL bd_space1 got=%0d want=4", run_len[5]); end
    total++; if (run_len[7] != 12) begin bad++; $display("FAIL bd_space2 got=%0d want=12", run_len[7]); end
    total++; if (odd != 0) begin bad++; $display("FAIL bd_space_len odd=%0d want=0", odd); end
    total++; if (word !== 32'hF708FB04) begin bad++; $display("FAIL bd_word got=%h want=f708fb04", word); end
  endtask

  task automatic test_repeat();
    int hi, dfirst, dcnt;
    send(1'b1, 8'hAA, 8'h55, 1'b0);
    capture(130);
    decode(130);
    total++; if (run_lvl[0] !== 1'b1 || run_len[0] != 64) begin
      bad++; $display("FAIL rp_mark got=%b/%0d want=1/64", run_lvl[0], run_len[0]); end
    total++; if (run_len[1] != 16) begin bad++; $display("FAIL rp_space got=%0d want=16", run_len[1]); end
    total++; if (run_lvl[2] !== 1'b1 || run_len[2] != 4) begin
      bad++; $display("FAIL rp_stop got=%b/%0d want=1/4", run_lvl[2], run_len[2]); end
    hi = 0; dfirst = 0; dcnt = 0;
    for (int k = 1; k <= 130; k++) begin
      if (env_a[k] === 1'b1) hi++;
      if (done_a[k] === 1'b1) begin dcnt++; if (dfirst == 0) dfirst = k; end
    end
    total++; if (hi != 68) begin bad++; $display("FAIL rp_high got=%0d want=68", hi); end
    total++; if (dfirst != 84 || dcnt != 1) begin
      bad++; $display("FAIL rp_done got=%0d/%0d want=84/1", dfirst, dcnt); end
    total++; if (rdy_a[116] !== 1'b0 || rdy_a[117] !== 1'b1) begin
      bad++; $display("FAIL rp_ready got=%b%b want=01", rdy_a[116], rdy_a[117]); end
  endtask

  task automatic test_carrier_back_to_back();
    int ms, cerr, ones, dfirst, acc2, w;
    logic expv;
    send(1'b0, 8'h00, 8'hFF, 1'b1);
    capture(530);
    tx_valid = 1'b0;
    ms = 1; cerr = 0; ones = 0; dfirst = 0; acc2 = 0;
    for (int k = 1; k <= 530; k++) begin
      if (env_a[k] === 1'b1 && (k == 1 || env_a[k-1] !== 1'b1)) ms = k;
      expv = (env_a[k] === 1'b1) && (((k - ms) % 3) == 0);
      if (out_a[k] !== expv) cerr++;
      if (k <= 484 && out_a[k] === 1'b1) ones++;
      if (done_a[k] === 1'b1 && dfirst == 0) dfirst = k;
      if (k > 1 && rdy_a[k] === 1'b1 && acc2 == 0) acc2 = k;
    end
    total++; if (cerr != 0) begin bad++; $display("FAIL cb_carrier_pattern errs=%0d want=0", cerr); end
    total++; if (ones != 88) begin bad++; $display("FAIL cb_carrier_pulses got=%0d want=88", ones); end
    total++; if (acc2 - dfirst != 33) begin
      bad++; $display("FAIL cb_accept_gap got=%0d want=33 (done=%0d acc=%0d)", acc2 - dfirst, dfirst, acc2); end
    total++; if (env_a[518] !== 1'b1) begin bad++; $display("FAIL cb_second_lead got=%b want=1", env_a[518]); end
    w = 0;
    while (tx_ready !== 1'b1 && w < 1000) begin step(); w++; end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL cb_drain got=%b want=1", tx_ready); end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    send(1'b0, 8'h12, 8'h34, 1'b0);
    capture(29);
    total++; if (ir_env !== 1'b1) begin bad++; $display("FAIL rm_pre_env got=%b want=1", ir_env); end
    rst_n = 1'b0;
    #1;
    total++; if (ir_env !== 1'b0) begin bad++; $display("FAIL rm_env got=%b want=0", ir_env); end
    total++; if (ir_out !== 1'b0) begin bad++; $display("FAIL rm_out got=%b want=0", ir_out); end
    total++; if (tx_busy !== 1'b0 || led !== 1'b0) begin
      bad++; $display("FAIL rm_busy got=%b%b want=00", tx_busy, led); end
    step(); step(); step();
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 600; k++) begin
      if (tx_done === 1'b1) dcnt++;
      step();
    end
    total++; if (dcnt != 0) begin bad++; $display("FAIL rm_no_done got=%0d want=0", dcnt); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", tx_ready); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_bit_decode();
    test_repeat();
    test_carrier_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
